// File: rtl/debouncer_if.sv
// debouncer_if -- pin bundle for the two-channel PS/2 debouncer.
//   I0, I1 : raw asynchronous inputs (PS/2 clock, PS/2 data)
//   O0, O1 : registered, debounced outputs
// master drives the raw lines and observes the outputs; slave is the debouncer.
interface debouncer_if;
  logic I0;
  logic I1;
  logic O0;
  logic O1;

  modport master (output I0, output I1, input O0, input O1);
  modport slave  (input I0, input I1, output O0, output O1);
endinterface

// File: rtl/debouncer.sv
// debouncer -- two independent debounce channels for PS/2 clock/data lines.
//   clk : system clock, all state updates on the rising edge
//   rst : synchronous active-high reset; every channel returns to IDLE_LEVEL
//   bus : debouncer_if.slave (I0/I1 raw in, O0/O1 debounced out)
// Each output changes only after its synchronized sample has held the same
// level for STABLE_CYCLES+1 consecutive clocks. End-to-end latency for a held
// input step is SYNC_STAGES+STABLE_CYCLES+1 edges.

// One channel: synchronizer chain, candidate level v, stability counter cnt.
module debouncer_lane #(
  parameter int unsigned STABLE_CYCLES = 19,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter logic        IDLE_LEVEL    = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);
  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_FIRE = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   v;
  logic [CW-1:0]          cnt;

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= {SYNC_STAGES{IDLE_LEVEL}};
      v    <= IDLE_LEVEL;
      // Start saturated so an idle line produces no output edge after reset.
      cnt  <= CNT_SAT;
      dout <= IDLE_LEVEL;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      if (s != v) begin
        // Any toggle restarts the count with the newest level.
        v   <= s;
        cnt <= '0;
      end else if (cnt != CNT_SAT) begin
        cnt <= cnt + 1'b1;
        // The sample that loaded v plus STABLE_CYCLES matches -> commit.
        if (cnt == CNT_FIRE) dout <= v;
      end
    end
  end
endmodule

module debouncer #(
  parameter int unsigned STABLE_CYCLES = 19,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter logic        IDLE_LEVEL    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  debouncer_if.slave  bus
);
  localparam int NUM_LANES = 2;

  logic [NUM_LANES-1:0] din;
  logic [NUM_LANES-1:0] dout;

  assign din     = {bus.I1, bus.I0};
  assign bus.O0  = dout[0];
  assign bus.O1  = dout[1];

  // Fully independent channels: no shared counter or state.
  debouncer_lane #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES),
    .IDLE_LEVEL    (IDLE_LEVEL)
  ) u_lane [NUM_LANES-1:0] (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .dout (dout)
  );
endmodule

// File: tb/tb_debouncer.sv
// tb_debouncer -- self-checking bench for debouncer (default parameters).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Reference model: an output takes level x once the last STABLE+1 synchronized
// samples (raw input delayed SYNC_STAGES edges) all equal x, else it holds.
module tb_debouncer;
  localparam int   SC    = 19;
  localparam int   SS    = 2;
  localparam logic IDLE  = 1'b1;
  localparam int   DEPTH = SS + SC + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  debouncer_if bus ();

  debouncer #(.STABLE_CYCLES(SC), .SYNC_STAGES(SS), .IDLE_LEVEL(IDLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic h0 [DEPTH];
  logic h1 [DEPTH];
  logic m_o0, m_o1;

  function automatic logic window_eq(input logic h [DEPTH], output logic lvl);
    lvl = h[SS];
    for (int k = SS; k < DEPTH; k++) if (h[k] !== lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    logic lvl;
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin h0[k] = IDLE; h1[k] = IDLE; end
      m_o0 = IDLE; m_o1 = IDLE;
    end else begin
      for (int k = DEPTH - 1; k > 0; k--) begin h0[k] = h0[k-1]; h1[k] = h1[k-1]; end
      h0[0] = bus.I0; h1[0] = bus.I1;
      if (window_eq(h0, lvl)) m_o0 = lvl;
      if (window_eq(h1, lvl)) m_o1 = lvl;
    end
  endtask

  // One clock: model observes the same inputs the DUT samples.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
    end
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1; step(2); rst = 1'b0;
  endtask

  typedef struct {
    logic i0, i1;
    int   hold;
    logic e0, e1;
  } vec_t;

  vec_t vt [8];
  int   zeros, lows, toggles, first_low, o_prev0, o_prev1;

  initial begin
    vt[0] = '{1'b0, 1'b1, 25, 1'b0, 1'b1};
    vt[1] = '{1'b0, 1'b0, 25, 1'b0, 1'b0};
    vt[2] = '{1'b1, 1'b0, 10, 1'b0, 1'b0};
    vt[3] = '{1'b1, 1'b0, 15, 1'b1, 1'b0};
    vt[4] = '{1'b1, 1'b1, 22, 1'b1, 1'b1};
    vt[5] = '{1'b0, 1'b1, 21, 1'b1, 1'b1};
    vt[6] = '{1'b0, 1'b1,  1, 1'b0, 1'b1};
    vt[7] = '{1'b1, 1'b1,  5, 1'b0, 1'b1};

    bus.I0 = 1'b1; bus.I1 = 1'b1;
    @(negedge clk);

    // Reset with idle inputs, then 50 quiet cycles.
    do_reset();
    chk("reset_o0", bus.O0, IDLE);
    chk("reset_o1", bus.O1, IDLE);
    toggles = 0; o_prev0 = bus.O0; o_prev1 = bus.O1;
    for (int c = 0; c < 50; c++) begin
      step(1);
      if (bus.O0 !== o_prev0[0] || bus.O1 !== o_prev1[0]) toggles++;
      if (bus.O0 !== 1'b1 || bus.O1 !== 1'b1) toggles++;
    end
    chk_int("idle_hold_toggles", toggles, 0);

    // Table-driven vectors.
    for (int r = 0; r < 8; r++) begin
      bus.I0 = vt[r].i0; bus.I1 = vt[r].i1;
      step(vt[r].hold);
      chk($sformatf("vec%0d_o0", r), bus.O0, vt[r].e0);
      chk($sformatf("vec%0d_o1", r), bus.O1, vt[r].e1);
    end

    // Exact latency: edge 21 unchanged, edge 22 changed.
    bus.I0 = 1'b1; bus.I1 = 1'b1; step(40);
    bus.I0 = 1'b0;
    step(21); chk("lat_edge21_o0", bus.O0, 1'b1);
    step(1);  chk("lat_edge22_o0", bus.O0, 1'b0);
    chk("lat_o1_unchanged", bus.O1, 1'b1);
    bus.I0 = 1'b1; step(40);

    // Glitch of 19 cycles rejected.
    bus.I0 = 1'b0; step(19); bus.I0 = 1'b1;
    zeros = 0;
    for (int c = 0; c < 40; c++) begin step(1); if (bus.O0 !== 1'b1) zeros++; end
    chk_int("glitch19_o0_lows", zeros, 0);

    // Pulse of 20 cycles passes, lasts 20 cycles, first low at edge 22.
    bus.I0 = 1'b0; lows = 0; first_low = -1;
    for (int c = 1; c <= 70; c++) begin
      if (c == 21) bus.I0 = 1'b1;
      step(1);
      if (bus.O0 === 1'b0) begin lows++; if (first_low < 0) first_low = c; end
    end
    chk_int("pulse20_o0_lows", lows, 20);
    chk_int("pulse20_first_low_edge", first_low, SS + SC + 1);
    chk("pulse20_o0_back", bus.O0, 1'b1);

    // Bouncing I1, then settle low.
    zeros = 0;
    for (int t = 0; t < 20; t++) begin
      bus.I1 = ~bus.I1;
      for (int c = 0; c < 5; c++) begin step(1); if (bus.O1 !== 1'b1) zeros++; end
    end
    chk_int("bounce_o1_lows", zeros, 0);
    bus.I1 = 1'b0;
    step(21); chk("bounce_edge21_o1", bus.O1, 1'b1);
    step(1);  chk("bounce_edge22_o1", bus.O1, 1'b0);
    bus.I1 = 1'b1; step(40);

    // Reset mid-count discards the pending count.
    bus.I0 = 1'b0; step(10);
    rst = 1'b1; step(1);
    chk("midrst_o0_reset", bus.O0, 1'b1);
    rst = 1'b0;
    step(21); chk("midrst_edge21_o0", bus.O0, 1'b1);
    step(1);  chk("midrst_edge22_o0", bus.O0, 1'b0);
    bus.I0 = 1'b1; step(40);

    // Simultaneous fall on both channels.
    bus.I0 = 1'b0; bus.I1 = 1'b0;
    step(21);
    chk("simul_edge21_o0", bus.O0, 1'b1);
    chk("simul_edge21_o1", bus.O1, 1'b1);
    step(1);
    chk("simul_edge22_o0", bus.O0, 1'b0);
    chk("simul_edge22_o1", bus.O1, 1'b0);

    // Randomized runs against the model, with occasional resets.
    for (int r = 0; r < 150; r++) begin
      int run;
      logic n0, n1;
      run = $urandom_range(1, 30);
      n0 = 1'($urandom_range(0, 1));
      n1 = 1'($urandom_range(0, 1));
      bus.I0 = n0; bus.I1 = n1;
      if ($urandom_range(0, 24) == 0) rst = 1'b1;
      for (int c = 0; c < run; c++) begin
        step(1);
        rst = 1'b0;
        chk("rand_o0", bus.O0, m_o0);
        chk("rand_o1", bus.O1, m_o1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
